// File: rtl/cmd_pkg.sv
// Shared widths and FSM state types for the command router.
package cmd_pkg;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {R_IDLE, R_LEN, R_DATA, R_DROP} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_ADDR, T_LEN, T_DATA} tx_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority select: first req at or after ptr (wrapping) wins.
// Purely combinational; grant is one-hot, idx is its binary index.
module rr_arbiter #(
  parameter int N = 9,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end
endmodule

// File: rtl/cmd_router.sv
// Host packet router: rx [ADDR][LEN][payload] -> one-hot slave strobes (1 cycle latency);
// tx drains slave messages round-robin into the same packet format, holding tx_valid until accepted.
module cmd_router
  import cmd_pkg::*;
#(
  parameter int N_SLAVES = 9,
  parameter int TIMEOUT  = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            master_data,
  output logic [N_SLAVES-1:0]   valid_bus,
  input  logic [N_SLAVES-1:0]   have_msg_bus,
  input  logic [8*N_SLAVES-1:0] len_bus,
  input  logic [8*N_SLAVES-1:0] slave_data_bus,
  output logic [N_SLAVES-1:0]   rdreq_bus,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  err_addr,
  output logic                  err_timeout
);
  localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] N_ADDR = ADDR_W'(N_SLAVES);
  localparam logic [SW-1:0]     LAST   = SW'(N_SLAVES - 1);

  rx_state_t         rstate;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  cnt;
  logic [TW-1:0]     tmo;

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate      <= R_IDLE;
      addr        <= '0;
      cnt         <= '0;
      tmo         <= '0;
      master_data <= '0;
      valid_bus   <= '0;
      err_addr    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      valid_bus   <= '0;
      err_addr    <= 1'b0;
      err_timeout <= 1'b0;
      if (rx_valid) begin
        tmo <= '0;
        case (rstate)
          R_IDLE: begin
            addr   <= rx_data;
            rstate <= R_LEN;
          end
          R_LEN: begin
            cnt <= rx_data;
            if (addr >= N_ADDR) err_addr <= 1'b1;
            if (rx_data == '0)        rstate <= R_IDLE;
            else if (addr < N_ADDR)   rstate <= R_DATA;
            else                      rstate <= R_DROP;
          end
          R_DATA: begin
            master_data <= rx_data;
            valid_bus   <= N_SLAVES'(1) << addr;
            cnt         <= cnt - 1'b1;
            if (cnt == LEN_W'(1)) rstate <= R_IDLE;
          end
          default: begin
            cnt <= cnt - 1'b1;
            if (cnt == LEN_W'(1)) rstate <= R_IDLE;
          end
        endcase
      end else if (rstate == R_IDLE) begin
        tmo <= '0;
      end else if (tmo == TW'(TIMEOUT - 1)) begin
        // abort only the parser; strobes already issued stand
        rstate      <= R_IDLE;
        tmo         <= '0;
        err_timeout <= 1'b1;
      end else begin
        tmo <= tmo + 1'b1;
      end
    end
  end

  logic [7:0] len_arr [N_SLAVES];
  logic [7:0] dat_arr [N_SLAVES];
  for (genvar g = 0; g < N_SLAVES; g++) begin : g_unpack
    assign len_arr[g] = len_bus[8*g +: 8];
    assign dat_arr[g] = slave_data_bus[8*g +: 8];
  end

  tx_state_t             tstate;
  logic [SW-1:0]         sel, rr_ptr, arb_idx;
  logic [N_SLAVES-1:0]   sel_oh, arb_grant;
  logic                  arb_any;
  logic [LEN_W-1:0]      tlen;
  logic [7:0]            tx_hdr;

  rr_arbiter #(.N(N_SLAVES)) u_arb (
    .req   (have_msg_bus),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Payload bytes come straight from the show-ahead head so the next byte follows each pop.
  assign tx_data   = (tstate == T_DATA) ? dat_arr[sel] : tx_hdr;
  assign rdreq_bus = (tstate == T_DATA && tx_valid && tx_ready) ? sel_oh : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      tstate   <= T_IDLE;
      tx_valid <= 1'b0;
      tx_hdr   <= '0;
      sel      <= '0;
      sel_oh   <= '0;
      rr_ptr   <= '0;
      tlen     <= '0;
    end else begin
      case (tstate)
        T_IDLE: if (arb_any) begin
          sel      <= arb_idx;
          sel_oh   <= arb_grant;
          tlen     <= len_arr[arb_idx];
          tx_hdr   <= ADDR_W'(arb_idx);
          tx_valid <= 1'b1;
          tstate   <= T_ADDR;
        end
        T_ADDR: if (tx_ready) begin
          tx_hdr <= tlen;
          tstate <= T_LEN;
        end
        T_LEN: if (tx_ready) begin
          if (tlen != '0) begin
            tstate <= T_DATA;
          end else begin
            tx_valid <= 1'b0;
            rr_ptr   <= (sel == LAST) ? '0 : sel + 1'b1;
            tstate   <= T_IDLE;
          end
        end
        default: if (tx_ready) begin
          tlen <= tlen - 1'b1;
          if (tlen == LEN_W'(1)) begin
            tx_valid <= 1'b0;
            rr_ptr   <= (sel == LAST) ? '0 : sel + 1'b1;
            tstate   <= T_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cmd_router.sv
// Scoreboard bench for cmd_router: packet-level rx model and round-robin tx model feed
// expectation queues that a free-running negedge monitor pops and compares.
module tb_cmd_router;
  localparam int N   = 9;
  localparam int TMO = 64;
  localparam int K_DATA = 0, K_ADDR = 1, K_TMO = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic [7:0]     master_data;
  logic [N-1:0]   valid_bus;
  logic [N-1:0]   have_msg_bus;
  logic [8*N-1:0] len_bus;
  logic [8*N-1:0] slave_data_bus;
  logic [N-1:0]   rdreq_bus;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic           err_addr;
  logic           err_timeout;

  cmd_router #(.N_SLAVES(N), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .master_data    (master_data),
    .valid_bus      (valid_bus),
    .have_msg_bus   (have_msg_bus),
    .len_bus        (len_bus),
    .slave_data_bus (slave_data_bus),
    .rdreq_bus      (rdreq_bus),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .err_addr       (err_addr),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  function automatic void check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  typedef struct { int kind; int addr; int data; int at; } rx_ev_t;
  typedef struct { int data; int rd; } tx_ev_t;
  rx_ev_t rxq[$];
  tx_ev_t txq[$];

  logic [7:0] sbytes[N][$];
  int         slens[N][$];
  int         spop[N];
  logic [7:0] mbytes[N][$];
  int         mlens[N][$];
  int         mptr = 0;
  logic [7:0] rpl[$];
  logic [7:0] tpl[$];
  logic [N-1:0] pop_vec;
  int         ready_mode;
  bit         stall;
  logic [7:0] held;

  // ---------------- rx stimulus + packet-level model ----------------
  task automatic rx_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic rx_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_pkt(input int addr, input int len, input int gmax);
    rx_byte(8'(addr));
    rx_idle(int'($urandom_range(0, gmax)));
    rx_byte(8'(len));
    if (addr >= N) rxq.push_back('{K_ADDR, addr, 0, cyc + 1});
    foreach (rpl[i]) begin
      rx_idle(int'($urandom_range(0, gmax)));
      rx_byte(rpl[i]);
      if (addr < N) rxq.push_back('{K_DATA, addr, int'(rpl[i]), cyc + 1});
    end
  endtask

  // ---------------- slave model + tx reference ----------------
  task automatic update_slaves();
    for (int i = 0; i < N; i++) begin
      have_msg_bus[i]         = (slens[i].size() > 0);
      len_bus[8*i +: 8]        = (slens[i].size() > 0) ? 8'(slens[i][0]) : 8'h00;
      slave_data_bus[8*i +: 8] = (sbytes[i].size() > 0) ? sbytes[i][0] : 8'h00;
    end
  endtask

  task automatic tx_cycle();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (pop_vec[i] && sbytes[i].size() > 0) begin
        void'(sbytes[i].pop_front());
        spop[i]++;
        if (slens[i].size() > 0 && spop[i] == slens[i][0]) begin
          void'(slens[i].pop_front());
          spop[i] = 0;
        end
      end
    end
    pop_vec = '0;
    update_slaves();
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic add_msg(input int s);
    slens[s].push_back(tpl.size());
    mlens[s].push_back(tpl.size());
    foreach (tpl[k]) begin
      sbytes[s].push_back(tpl[k]);
      mbytes[s].push_back(tpl[k]);
    end
  endtask

  // Expected host stream: repeatedly serve the first pending slave at or after the pointer.
  task automatic model_drain();
    for (int guard = 0; guard < 1000; guard++) begin
      int sel, len;
      sel = -1;
      for (int k = 0; k < N; k++)
        if (sel < 0 && mlens[(mptr + k) % N].size() > 0) sel = (mptr + k) % N;
      if (sel < 0) break;
      len = mlens[sel].pop_front();
      txq.push_back('{sel, 0});
      txq.push_back('{len, 0});
      for (int j = 0; j < len; j++) txq.push_back('{int'(mbytes[sel].pop_front()), 1 << sel});
      mptr = (sel + 1) % N;
    end
  endtask

  function automatic bit slaves_empty();
    for (int i = 0; i < N; i++) if (slens[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_batch(input int mode, output bit ok);
    ready_mode = mode;
    update_slaves();
    model_drain();
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      tx_cycle();
      if (txq.size() == 0 && slaves_empty()) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL tx_drain: %0d host bytes still expected after 3000 cycles", txq.size());
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    rx_ev_t e;
    tx_ev_t te;
    pop_vec = '0;
    stall   = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (valid_bus != '0 || err_addr || err_timeout) begin
        if (rxq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rx_spurious: valid_bus=0x%0h err_addr=%0b err_timeout=%0b, expected none (cycle %0d)",
                   valid_bus, err_addr, err_timeout, cyc);
        end else begin
          e = rxq.pop_front();
          case (e.kind)
            K_DATA: begin
              check("valid_bus", int'(valid_bus), 1 << e.addr);
              check("master_data", int'(master_data), e.data);
              check("rx_latency", cyc, e.at);
            end
            K_ADDR: begin
              check("err_addr", int'(err_addr), 1);
              check("valid_bus_on_bad_addr", int'(valid_bus), 0);
              check("err_addr_cycle", cyc, e.at);
            end
            default: begin
              check("err_timeout", int'(err_timeout), 1);
              check("err_timeout_cycle", (cyc >= e.at - 1 && cyc <= e.at + 1) ? e.at : cyc, e.at);
            end
          endcase
        end
      end

      if (stall) check("tx_hold", int'({tx_valid, tx_data}), int'({1'b1, held}));
      if (tx_valid && tx_ready) begin
        if (txq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tx_spurious: tx_data=0x%0h accepted, expected no byte (cycle %0d)", tx_data, cyc);
        end else begin
          te = txq.pop_front();
          check("tx_data", int'(tx_data), te.data);
          check("rdreq_bus", int'(rdreq_bus), te.rd);
        end
      end else if (rdreq_bus != '0) begin
        check("rdreq_no_handshake", int'(rdreq_bus), 0);
      end
      stall   = tx_valid && !tx_ready;
      held    = tx_data;
      pop_vec = rdreq_bus;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
    have_msg_bus = '0; len_bus = '0; slave_data_bus = '0;
    tx_ready = 1'b0; ready_mode = 0;
    for (int i = 0; i < N; i++) spop[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_master_data", int'(master_data), 0);
    check("rst_valid_bus", int'(valid_bus), 0);
    check("rst_rdreq_bus", int'(rdreq_bus), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_tx_valid", int'(tx_valid), 0);
    check("rst_err_addr", int'(err_addr), 0);
    check("rst_err_timeout", int'(err_timeout), 0);

    fork
      begin : rx_side
        rpl.delete(); rpl.push_back(8'h11); rpl.push_back(8'h22); rpl.push_back(8'h33);
        send_pkt(2, 3, 0);
        rpl.delete(); rpl.push_back(8'hAA); rpl.push_back(8'hBB);
        send_pkt(8'h0C, 2, 0);
        rpl.delete(); rpl.push_back(8'h05);
        send_pkt(0, 1, 0);
        rpl.delete(); rpl.push_back(8'h10);
        send_pkt(1, 4, 0);
        rxq.push_back('{K_TMO, 0, 0, cyc + TMO + 1});
        rx_idle(TMO + 5);
        rpl.delete(); rpl.push_back(8'h7E);
        send_pkt(1, 1, 0);
        rpl.delete();
        send_pkt(8'h0A, 0, 0);
        for (int p = 0; p < 40; p++) begin
          int a, l;
          a = int'($urandom_range(0, 11));
          l = int'($urandom_range(0, 5));
          rpl.delete();
          for (int k = 0; k < l; k++) rpl.push_back(8'($urandom));
          send_pkt(a, l, 2);
        end
        rx_idle(2);
      end
      begin : tx_side
        tx_cycle();
        tpl.delete(); tpl.push_back(8'h50);
        add_msg(0);
        tpl.delete(); tpl.push_back(8'h81); tpl.push_back(8'h82);
        add_msg(8);
        run_batch(0, ok);
        if (ok) begin
          tpl.delete(); tpl.push_back(8'hC1); tpl.push_back(8'hC2);
          add_msg(3);
          run_batch(0, ok);
        end
        if (ok) begin
          tpl.delete();
          for (int k = 0; k < 4; k++) tpl.push_back(8'($urandom));
          add_msg(5);
          tx_ready = 1'b0;
          run_batch(1, ok);
        end
        for (int b = 0; b < 10 && ok; b++) begin
          for (int s = 0; s < N; s++) begin
            if ($urandom_range(0, 1) == 1) begin
              int nm;
              nm = int'($urandom_range(1, 2));
              for (int m = 0; m < nm; m++) begin
                tpl.delete();
                for (int k = 0; k < int'($urandom_range(1, 5)); k++) tpl.push_back(8'($urandom));
                add_msg(s);
              end
            end
          end
          run_batch(2, ok);
        end
      end
    join

    // A reset mid-packet must drop the parser back to idle.
    rpl.delete(); rpl.push_back(8'h44);
    send_pkt(2, 3, 0);
    @(posedge clk); #1;
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
    @(posedge clk); #1;
    rst = 1'b0; rx_valid = 1'b0;
    rpl.delete(); rpl.push_back(8'h99);
    send_pkt(4, 1, 0);
    rx_idle(5);

    check("rx_leftover", rxq.size(), 0);
    check("tx_leftover", txq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
